// File: rtl/arc_engine_if.sv
// Request/plot bundle for arc_engine: start/done handshake plus the VGA plot port.
// Master issues draw requests and consumes plots; slave is the engine.
interface arc_engine_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      centre_x;
    logic [Y_W-1:0]      centre_y;
    logic [R_W-1:0]      radius;
    logic [COLOUR_W-1:0] colour;
    logic [7:0]          octant_mask;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, centre_x, centre_y, radius, colour, octant_mask,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, centre_x, centre_y, radius, colour, octant_mask,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/arc_engine.sv
// Midpoint circle/arc drawer, one octant slot per clock; done after 8N+2 edges, start held until done.
// No backpressure on the plot port. ARC_ENGINE_CLEAR_EN adds a full-screen blanking sweep before drawing.
module arc_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    arc_engine_if.slave bus
);
    localparam int MW = (X_W > R_W) ? ((X_W > Y_W) ? X_W : Y_W) : ((R_W > Y_W) ? R_W : Y_W);
    localparam int W  = MW + 2;
    localparam int CW = R_W + 2;
    localparam logic signed [W-1:0] ZERO = '0;
    localparam logic signed [W-1:0] ONE  = W'(1);
    localparam logic signed [W-1:0] SW_S = W'(SCREEN_W);
    localparam logic signed [W-1:0] SH_S = W'(SCREEN_H);

    typedef enum logic [2:0] {IDLE, INIT, CLEAR, DRAW, DONE} state_t;

    state_t               state;
    logic [X_W-1:0]       cx_q;
    logic [Y_W-1:0]       cy_q;
    logic [R_W-1:0]       rad_q;
    logic [COLOUR_W-1:0]  col_q;
    logic [7:0]           mask_q;
    logic signed [W-1:0]  ox, oy;
    logic signed [CW-1:0] crit;
    logic [2:0]           k;
`ifdef ARC_ENGINE_CLEAR_EN
    logic [X_W-1:0]       clr_x;
    logic [Y_W-1:0]       clr_y;
`endif

    logic signed [W-1:0] cx_s, cy_s, rad_s, px, py, oy_n, ox_n, crit_w, crit_n;
    logic                on_screen;

    always_comb begin
        cx_s  = $signed(W'(cx_q));
        cy_s  = $signed(W'(cy_q));
        rad_s = $signed(W'(rad_q));
        px    = cx_s;
        py    = cy_s;
        case (k)
            3'd0: begin px = cx_s + ox; py = cy_s + oy; end
            3'd1: begin px = cx_s + oy; py = cy_s + ox; end
            3'd2: begin px = cx_s - oy; py = cy_s + ox; end
            3'd3: begin px = cx_s - ox; py = cy_s + oy; end
            3'd4: begin px = cx_s - ox; py = cy_s - oy; end
            3'd5: begin px = cx_s - oy; py = cy_s - ox; end
            3'd6: begin px = cx_s + oy; py = cy_s - ox; end
            3'd7: begin px = cx_s + ox; py = cy_s - oy; end
        endcase
        on_screen = (px >= ZERO) && (px < SW_S) && (py >= ZERO) && (py < SH_S);

        // Midpoint step evaluated with the already-incremented oy (and decremented ox).
        oy_n   = oy + ONE;
        crit_w = W'(crit);
        if (crit_w <= ZERO) begin
            ox_n   = ox;
            crit_n = crit_w + oy_n + oy_n + ONE;
        end else begin
            ox_n   = ox - ONE;
            crit_n = crit_w + (oy_n - ox_n) + (oy_n - ox_n) + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.done       <= 1'b0;
            bus.vga_plot   <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            cx_q           <= '0;
            cy_q           <= '0;
            rad_q          <= '0;
            col_q          <= '0;
            mask_q         <= '0;
            ox             <= '0;
            oy             <= '0;
            crit           <= '0;
            k              <= '0;
`ifdef ARC_ENGINE_CLEAR_EN
            clr_x          <= '0;
            clr_y          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done       <= 1'b0;
                    bus.vga_plot   <= 1'b0;
                    bus.vga_x      <= '0;
                    bus.vga_y      <= '0;
                    bus.vga_colour <= '0;
                    if (bus.start) begin
                        cx_q   <= bus.centre_x;
                        cy_q   <= bus.centre_y;
                        rad_q  <= bus.radius;
                        col_q  <= bus.colour;
                        mask_q <= bus.octant_mask;
                        state  <= INIT;
                    end
                end
                INIT: begin
                    ox   <= rad_s;
                    oy   <= ZERO;
                    crit <= CW'(ONE - rad_s);
                    k    <= 3'd0;
`ifdef ARC_ENGINE_CLEAR_EN
                    clr_x <= '0;
                    clr_y <= '0;
                    state <= CLEAR;
`else
                    state <= DRAW;
`endif
                end
`ifdef ARC_ENGINE_CLEAR_EN
                CLEAR: begin
                    bus.vga_x      <= clr_x;
                    bus.vga_y      <= clr_y;
                    bus.vga_colour <= '0;
                    bus.vga_plot   <= 1'b1;
                    if (clr_y == Y_W'(SCREEN_H - 1)) begin
                        clr_y <= '0;
                        if (clr_x == X_W'(SCREEN_W - 1)) state <= DRAW;
                        else clr_x <= clr_x + X_W'(1);
                    end else begin
                        clr_y <= clr_y + Y_W'(1);
                    end
                end
`endif
                DRAW: begin
                    bus.vga_x      <= px[X_W-1:0];
                    bus.vga_y      <= py[Y_W-1:0];
                    bus.vga_colour <= col_q;
                    bus.vga_plot   <= mask_q[k] & on_screen;
                    k              <= k + 3'd1;
                    if (k == 3'd7) begin
                        oy   <= oy_n;
                        ox   <= ox_n;
                        crit <= CW'(crit_n);
                        if (oy_n > ox_n) state <= DONE;
                    end
                end
                DONE: begin
                    bus.vga_plot   <= 1'b0;
                    bus.vga_x      <= '0;
                    bus.vga_y      <= '0;
                    bus.vga_colour <= '0;
                    if (!bus.done) begin
                        bus.done <= 1'b1;
                    end else if (!bus.start) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arc_engine.sv
module tb_arc_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arc_engine_if #(.X_W(8), .Y_W(7), .R_W(8), .COLOUR_W(3)) bus();

    arc_engine #(
        .X_W(8), .Y_W(7), .R_W(8), .COLOUR_W(3), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_x[$], exp_y[$], exp_c[$];
    int obs_x[$], obs_y[$], obs_c[$];
    int done_edge;
    logic plot_at_done;

    // Golden midpoint model: pushes every expected plotted pixel, returns iteration count N.
    function automatic int model(input int cx, input int cy, input int r, input int col,
                                 input logic [7:0] mask);
        int x, y, d, n, px, py;
        x = r; y = 0; d = 1 - r; n = 0;
        exp_x.delete(); exp_y.delete(); exp_c.delete();
        while (y <= x) begin
            for (int s = 0; s < 8; s++) begin
                case (s)
                    0: begin px = cx + x; py = cy + y; end
                    1: begin px = cx + y; py = cy + x; end
                    2: begin px = cx - y; py = cy + x; end
                    3: begin px = cx - x; py = cy + y; end
                    4: begin px = cx - x; py = cy - y; end
                    5: begin px = cx - y; py = cy - x; end
                    6: begin px = cx + y; py = cy - x; end
                    default: begin px = cx + x; py = cy - y; end
                endcase
                if (mask[s] && px >= 0 && px < 160 && py >= 0 && py < 120) begin
                    exp_x.push_back(px); exp_y.push_back(py); exp_c.push_back(col);
                end
            end
            n++;
            y++;
            if (d <= 0) d += 2 * y + 1;
            else begin
                x--;
                d += 2 * (y - x) + 1;
            end
        end
        return n;
    endfunction

    function automatic bit has(input int x, input int y);
        foreach (obs_x[i]) if (obs_x[i] == x && obs_y[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    // Drives one request and records plots until done (bounded); leaves start high.
    task automatic draw(input int cx, input int cy, input int r, input int col, input logic [7:0] mask);
        obs_x.delete(); obs_y.delete(); obs_c.delete();
        @(negedge clk);
        bus.centre_x = 8'(cx); bus.centre_y = 7'(cy); bus.radius = 8'(r);
        bus.colour = 3'(col); bus.octant_mask = mask; bus.start = 1'b1;
        @(posedge clk);
        done_edge = -1;
        plot_at_done = 1'b0;
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk); #1;
            if (bus.vga_plot) begin
                obs_x.push_back(int'(bus.vga_x)); obs_y.push_back(int'(bus.vga_y));
                obs_c.push_back(int'(bus.vga_colour));
            end
            if (bus.done) begin
                done_edge = e;
                plot_at_done = bus.vga_plot;
                break;
            end
        end
    endtask

    task automatic release_start();
        @(negedge clk); bus.start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.centre_x = '0; bus.centre_y = '0; bus.radius = '0;
        bus.colour = '0; bus.octant_mask = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.vga_plot !== 1'b0 || bus.vga_x !== 8'd0 ||
            bus.vga_y !== 7'd0 || bus.vga_colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b plot=%b x=%0d y=%0d c=%0d required all 0",
                     bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_radius_zero();
        int n, ex, ey, ec, ax, ay, ac;
        n = model(80, 60, 0, 2, 8'hFF);
        draw(80, 60, 0, 2, 8'hFF);
        checks++;
        if (done_edge !== 8 * n + 2 || done_edge !== 10) begin
            errors++; $display("FAIL r0_done_edge: got %0d required 10", done_edge);
        end
        checks++;
        if (obs_x.size() !== 8 || exp_x.size() !== 8) begin
            errors++; $display("FAIL r0_plot_count: got %0d required 8", obs_x.size());
        end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            ex = exp_x.pop_front(); ey = exp_y.pop_front(); ec = exp_c.pop_front();
            ax = obs_x.pop_front(); ay = obs_y.pop_front(); ac = obs_c.pop_front();
            checks++;
            if (ax !== ex || ay !== ey || ac !== ec) begin
                errors++;
                $display("FAIL r0_pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", ax, ay, ac, ex, ey, ec);
            end
        end
        checks++;
        if (plot_at_done !== 1'b0) begin
            errors++; $display("FAIL r0_plot_in_done: got %b required 0", plot_at_done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL r0_done_held: got %b required 1", bus.done);
        end
        @(negedge clk); bus.start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL r0_done_drop: got %b required 0", bus.done);
        end
        @(posedge clk);
    endtask

    task automatic test_full_circle();
        int n, ex, ey, ec, ax, ay, ac;
        n = model(80, 60, 10, 5, 8'hFF);
        draw(80, 60, 10, 5, 8'hFF);
        checks++;
        if (n !== 8 || done_edge !== 66) begin
            errors++; $display("FAIL r10_done_edge: got %0d required 66 (model N=%0d)", done_edge, n);
        end
        checks++;
        if (!(has(90, 60) && has(80, 70) && has(70, 60) && has(80, 50))) begin
            errors++; $display("FAIL r10_axis_points: got some of (90,60)(80,70)(70,60)(80,50) missing required all present");
        end
        checks++;
        if (obs_x.size() !== 64 || obs_x[56] !== 87 || obs_y[56] !== 67) begin
            errors++;
            $display("FAIL r10_last_iter: got count=%0d slot56=(%0d,%0d) required 64 and (87,67)",
                     obs_x.size(), obs_x.size() > 56 ? obs_x[56] : -1, obs_y.size() > 56 ? obs_y[56] : -1);
        end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            ex = exp_x.pop_front(); ey = exp_y.pop_front(); ec = exp_c.pop_front();
            ax = obs_x.pop_front(); ay = obs_y.pop_front(); ac = obs_c.pop_front();
            checks++;
            if (ax !== ex || ay !== ey || ac !== ec) begin
                errors++;
                $display("FAIL r10_pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", ax, ay, ac, ex, ey, ec);
            end
        end
        release_start();
    endtask

    task automatic test_octant_mask();
        int n, ex, ey, ec, ax, ay, ac;
        bit quad_ok;
        n = model(80, 60, 10, 7, 8'h03);
        draw(80, 60, 10, 7, 8'h03);
        checks++;
        if (done_edge !== 66) begin
            errors++; $display("FAIL mask_done_edge: got %0d required 66", done_edge);
        end
        checks++;
        if (obs_x.size() !== 16) begin
            errors++; $display("FAIL mask_plot_count: got %0d required 16", obs_x.size());
        end
        quad_ok = 1'b1;
        foreach (obs_x[i]) if (obs_x[i] < 80 || obs_y[i] < 60) quad_ok = 1'b0;
        checks++;
        if (!quad_ok) begin
            errors++; $display("FAIL mask_quadrant: got a point with x<80 or y<60 required none");
        end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            ex = exp_x.pop_front(); ey = exp_y.pop_front(); ec = exp_c.pop_front();
            ax = obs_x.pop_front(); ay = obs_y.pop_front(); ac = obs_c.pop_front();
            checks++;
            if (ax !== ex || ay !== ey || ac !== ec) begin
                errors++;
                $display("FAIL mask_pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", ax, ay, ac, ex, ey, ec);
            end
        end
        release_start();
    endtask

    task automatic test_clipping();
        int n, ex, ey, ec, ax, ay, ac;
        bit range_ok;
        n = model(0, 0, 5, 1, 8'hFF);
        draw(0, 0, 5, 1, 8'hFF);
        checks++;
        if (n !== 4 || done_edge !== 34) begin
            errors++; $display("FAIL clip_done_edge: got %0d required 34 (model N=%0d)", done_edge, n);
        end
        range_ok = 1'b1;
        foreach (obs_x[i]) if (obs_x[i] >= 160 || obs_y[i] >= 120) range_ok = 1'b0;
        checks++;
        if (!range_ok) begin
            errors++; $display("FAIL clip_negative: got a wrapped negative coordinate required none");
        end
        checks++;
        if (!(has(5, 0) && has(0, 5))) begin
            errors++; $display("FAIL clip_axis_points: got (5,0)=%0b (0,5)=%0b required both 1", has(5, 0), has(0, 5));
        end
        checks++;
        if (obs_x.size() !== exp_x.size()) begin
            errors++; $display("FAIL clip_plot_count: got %0d required %0d", obs_x.size(), exp_x.size());
        end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            ex = exp_x.pop_front(); ey = exp_y.pop_front(); ec = exp_c.pop_front();
            ax = obs_x.pop_front(); ay = obs_y.pop_front(); ac = obs_c.pop_front();
            checks++;
            if (ax !== ex || ay !== ey || ac !== ec) begin
                errors++;
                $display("FAIL clip_pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", ax, ay, ac, ex, ey, ec);
            end
        end
        release_start();
    endtask

    task automatic test_reset_mid_draw();
        int n, ex, ey, ec, ax, ay, ac;
        int wait_edges;
        wait_edges = int'($urandom_range(3, 60));
        @(negedge clk);
        bus.centre_x = 8'd80; bus.centre_y = 7'd60; bus.radius = 8'd10;
        bus.colour = 3'd4; bus.octant_mask = 8'hFF; bus.start = 1'b1;
        repeat (wait_edges) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.vga_plot !== 1'b0) begin
                errors++;
                $display("FAIL midreset_edge%0d: got done=%b plot=%b required 0 0", i, bus.done, bus.vga_plot);
            end
        end
        @(negedge clk); rst_n = 1'b1; bus.start = 1'b0;
        @(posedge clk);
        n = model(80, 60, 10, 4, 8'hFF);
        draw(80, 60, 10, 4, 8'hFF);
        checks++;
        if (done_edge !== 8 * n + 2) begin
            errors++; $display("FAIL midreset_done_edge: got %0d required %0d", done_edge, 8 * n + 2);
        end
        checks++;
        if (obs_x.size() !== 64) begin
            errors++; $display("FAIL midreset_plot_count: got %0d required 64", obs_x.size());
        end
        while (exp_x.size() > 0 && obs_x.size() > 0) begin
            ex = exp_x.pop_front(); ey = exp_y.pop_front(); ec = exp_c.pop_front();
            ax = obs_x.pop_front(); ay = obs_y.pop_front(); ac = obs_c.pop_front();
            checks++;
            if (ax !== ex || ay !== ey || ac !== ec) begin
                errors++;
                $display("FAIL midreset_pixel: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", ax, ay, ac, ex, ey, ec);
            end
        end
        release_start();
    endtask

    initial begin
        test_reset();
        test_radius_zero();
        test_full_circle();
        test_octant_mask();
        test_clipping();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
